// File: rtl/hamming_tmr_writer.sv
// Write side of the triplicated Hamming(7,4) store: encode, write three replicas,
// read them back and rewrite corrupted copies up to MAX_RETRY times.
module hamming_tmr_writer #(
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             inj_en,
  input  logic             inj_stuck,
  input  logic [1:0]       inj_replica,
  input  logic [6:0]       inj_mask,
  output logic [6:0]       rep_1,
  output logic [6:0]       rep_2,
  output logic [6:0]       rep_3,
  output logic             done,
  output logic [1:0]       status,
  output logic [2:0]       err_replica,
  output logic [CNT_W-1:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_CHECK,
    S_REWRITE,
    S_DONE
  } state_t;

  localparam logic [1:0]       ST_OK   = 2'b00;
  localparam logic [1:0]       ST_CORR = 2'b01;
  localparam logic [1:0]       ST_FAIL = 2'b10;
  localparam logic [CNT_W-1:0] L_MAX   = CNT_W'(MAX_RETRY);

  // Codeword bit i holds Hamming position i+1; parity sits at positions 1, 2 and 4.
  function automatic logic [6:0] f_encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
            d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  state_t           r_state;
  logic [6:0]       r_cw;
  logic             r_inj_en;
  logic             r_inj_stuck;
  logic [1:0]       r_inj_replica;
  logic [6:0]       r_inj_mask;
  logic [6:0]       r_rep [3];
  logic [2:0]       r_mm;
  logic [2:0]       r_err_acc;
  logic [CNT_W-1:0] r_retry;
  logic             r_in_ready;
  logic             r_done;
  logic [1:0]       r_status;
  logic [2:0]       r_err_replica;
  logic [CNT_W-1:0] r_retry_cnt;

  logic [2:0]       w_mm;
  logic [2:0]       w_tgt;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_mm  = '0;
    w_tgt = '0;
    for (int k = 0; k < 3; k++) begin
      w_mm[k]  = (r_rep[k] != r_cw);
      w_tgt[k] = (r_inj_replica == 2'(k + 1));
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cw          <= '0;
      r_inj_en      <= 1'b0;
      r_inj_stuck   <= 1'b0;
      r_inj_replica <= '0;
      r_inj_mask    <= '0;
      // NOTE: the replica array is reset because it is visible state, not scratch storage.
      for (int k = 0; k < 3; k++) r_rep[k] <= '0;
      r_mm          <= '0;
      r_err_acc     <= '0;
      r_retry       <= '0;
      r_in_ready    <= 1'b0;
      r_done        <= 1'b0;
      r_status      <= ST_OK;
      r_err_replica <= '0;
      r_retry_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_cw          <= f_encode(in_data);
            r_inj_en      <= inj_en;
            r_inj_stuck   <= inj_stuck;
            r_inj_replica <= inj_replica;
            r_inj_mask    <= inj_mask;
            r_in_ready    <= 1'b0;
            r_state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          for (int k = 0; k < 3; k++)
            r_rep[k] <= r_cw ^ ((r_inj_en && w_tgt[k]) ? r_inj_mask : 7'd0);
          r_err_acc <= '0;
          r_retry   <= '0;
          r_state   <= S_CHECK;
        end
        S_CHECK: begin
          r_mm      <= w_mm;
          r_err_acc <= r_err_acc | w_mm;
          if (w_mm == 3'b000 || r_retry == L_MAX) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_err_replica <= r_err_acc | w_mm;
            r_retry_cnt   <= r_retry;
            if (w_mm != 3'b000)      r_status <= ST_FAIL;
            else if (r_retry == '0)  r_status <= ST_OK;
            else                     r_status <= ST_CORR;
          end else begin
            r_state <= S_REWRITE;
          end
        end
        S_REWRITE: begin
          // A stuck fault corrupts its replica again on every rewrite.
          for (int k = 0; k < 3; k++)
            if (r_mm[k])
              r_rep[k] <= r_cw ^ ((r_inj_stuck && w_tgt[k]) ? r_inj_mask : 7'd0);
          r_retry <= r_retry + CNT_W'(1);
          r_state <= S_CHECK;
        end
        S_DONE: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign rep_1       = r_rep[0];
  assign rep_2       = r_rep[1];
  assign rep_3       = r_rep[2];
  assign done        = r_done;
  assign status      = r_status;
  assign err_replica = r_err_replica;
  assign retry_cnt   = r_retry_cnt;

endmodule

// File: tb/tb_hamming_tmr_writer.sv
// Directed bench for hamming_tmr_writer: hand-computed codewords, latencies and
// status for clean, corrected, stuck-fault, back-to-back and reset-abort cases.
module tb_hamming_tmr_writer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       inj_en;
  logic       inj_stuck;
  logic [1:0] inj_replica;
  logic [6:0] inj_mask;
  logic [6:0] rep_1, rep_2, rep_3;
  logic       done;
  logic [1:0] status;
  logic [2:0] err_replica;
  logic [1:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic [3:0] tbl [8];

  hamming_tmr_writer #(.MAX_RETRY(2), .CNT_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .inj_en      (inj_en),
    .inj_stuck   (inj_stuck),
    .inj_replica (inj_replica),
    .inj_mask    (inj_mask),
    .rep_1       (rep_1),
    .rep_2       (rep_2),
    .rep_3       (rep_3),
    .done        (done),
    .status      (status),
    .err_replica (err_replica),
    .retry_cnt   (retry_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns just after the accept edge (cycle accept+1).
  task automatic accept(input logic [3:0] d, input logic en, input logic stuck,
                        input logic [1:0] rep, input logic [6:0] mask);
    int n = 0;
    in_data     = d;
    inj_en      = en;
    inj_stuck   = stuck;
    inj_replica = rep;
    inj_mask    = mask;
    in_valid    = 1'b1;
    while (in_ready !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("ready_before_accept", in_ready, 1'b1);
    step();
    in_valid  = 1'b0;
    inj_en    = 1'b0;
    inj_stuck = 1'b0;
    inj_mask  = '0;
  endtask

  task automatic wait_done(input int start, output int l);
    l = start;
    while (done !== 1'b1 && l < 40) begin
      step();
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    inj_en = 1'b0; inj_stuck = 1'b0; inj_replica = '0; inj_mask = '0;
    tbl = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1110, 4'b0001, 4'b0010, 4'b0100};

    // Reset state
    #2;
    check("rst_rep1", rep_1, 7'd0);
    check("rst_done", done, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_status", status, 2'b00);
    step(); step();
    check("rst_held_ready", in_ready, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("ready_after_release", in_ready, 1'b1);

    // Clean write of 1010
    accept(4'b1010, 1'b0, 1'b0, 2'd0, 7'd0);
    check("clean_ready_low", in_ready, 1'b0);
    wait_done(1, lat);
    check("clean_latency", lat, 3);
    check("clean_rep1", rep_1, 7'b1010010);
    check("clean_rep2", rep_2, 7'b1010010);
    check("clean_rep3", rep_3, 7'b1010010);
    check("clean_status", status, 2'b00);
    check("clean_err", err_replica, 3'b000);
    check("clean_retry", retry_cnt, 2'd0);
    step();
    check("clean_done_pulse", done, 1'b0);
    check("clean_ready_back", in_ready, 1'b1);

    // Single transient fault on replica 2, repaired by one rewrite
    accept(4'b1100, 1'b1, 1'b0, 2'd2, 7'b0000100);
    step();
    check("corr_write_rep1", rep_1, 7'b1100001);
    check("corr_write_rep2", rep_2, 7'b1100101);
    check("corr_write_rep3", rep_3, 7'b1100001);
    wait_done(2, lat);
    check("corr_latency", lat, 5);
    check("corr_rep2", rep_2, 7'b1100001);
    check("corr_status", status, 2'b01);
    check("corr_err", err_replica, 3'b010);
    check("corr_retry", retry_cnt, 2'd1);
    step();

    // Stuck fault on replica 3 exhausts MAX_RETRY
    accept(4'b1111, 1'b1, 1'b1, 2'd3, 7'b1000000);
    step();
    check("stuck_write_rep3", rep_3, 7'b0111111);
    wait_done(2, lat);
    check("stuck_latency", lat, 7);
    check("stuck_rep3", rep_3, 7'b0111111);
    check("stuck_rep1", rep_1, 7'b1111111);
    check("stuck_status", status, 2'b10);
    check("stuck_err", err_replica, 3'b100);
    check("stuck_retry", retry_cnt, 2'd2);
    step(); step();
    check("stuck_status_held", status, 2'b10);

    // Target replica 0 with a full mask behaves as a clean write
    accept(4'b0110, 1'b1, 1'b0, 2'd0, 7'h7f);
    wait_done(1, lat);
    check("norep_latency", lat, 3);
    check("norep_rep3", rep_3, 7'b0110011);
    check("norep_status", status, 2'b00);
    step();
    inj_replica = '0;

    // in_valid held high with data changing every cycle
    check("b2b_ready_start", in_ready, 1'b1);
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_data = tbl[c];
      check($sformatf("b2b_ready_c%0d", c), in_ready, (c % 4 == 0) ? 1'b1 : 1'b0);
      if (c == 3) begin
        check("b2b_done_1", done, 1'b1);
        check("b2b_word1_rep1", rep_1, 7'b0011110);
      end
      if (c == 7) begin
        check("b2b_done_2", done, 1'b1);
        check("b2b_word2_rep2", rep_2, 7'b1111000);
      end
      step();
    end
    in_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of a REWRITE cycle
    accept(4'b1100, 1'b1, 1'b0, 2'd2, 7'b0000100);
    step();
    step();
    check("abort_rep1_before", rep_1, 7'b1100001);
    #3 rst_n = 1'b0;
    #1;
    check("abort_rep1", rep_1, 7'd0);
    check("abort_rep2", rep_2, 7'd0);
    check("abort_ready", in_ready, 1'b0);
    check("abort_err", err_replica, 3'b000);
    for (int c = 0; c < 3; c++) begin
      step();
      check("abort_no_done", done, 1'b0);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    check("abort_ready_back", in_ready, 1'b1);
    accept(4'b0000, 1'b0, 1'b0, 2'd0, 7'd0);
    wait_done(1, lat);
    check("zero_latency", lat, 3);
    check("zero_rep1", rep_1, 7'd0);
    check("zero_status", status, 2'b00);
    check("zero_retry", retry_cnt, 2'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
